sram_access_ctrl: RTL
=====================

// Module: sram_access_ctrl
// PURPOSE
//   Sequences one SRAM access per request: precharge, wordline and column select, then sense or write.
//   Drives the one-hot row decoder lines and column_mux col_select; captures column_mux data_out on reads.
//   Sits between the Tiny Tapeout user I/O front end and the 16x64 bit-cell array with its column mux.
// PARAMETERS
//   WORD_SIZE  4   bits per word; width of read/write data
//   NUM_WORDS  16  words per row; width of col_select; NUM_COLS = WORD_SIZE*NUM_WORDS = 64
//   NUM_ROWS   16  wordlines in the array
//   ADDR_W     8   log2(NUM_ROWS*NUM_WORDS); addr[7:4] is the row, addr[3:0] is the word
// PORTS
//   clk           in   1          system clock; everything is on the rising edge
//   rst           in   1          synchronous reset, active-high
//   req_valid     in   1          request present
//   req_ready     out  1          controller idle; request accepted when req_valid & req_ready
//   req_we        in   1          1 = write, 0 = read
//   req_addr      in   ADDR_W     word address
//   req_wdata     in   WORD_SIZE  write data
//   rsp_valid     out  1          one-cycle pulse; rsp_rdata is valid
//   rsp_rdata     out  WORD_SIZE  read data; held until the next read completes
//   precharge_en  out  1          bitline precharge strobe
//   row_sel       out  NUM_ROWS   one-hot wordline enable
//   col_select    out  NUM_WORDS  one-hot to column_mux
//   sense_en      out  1          sense-amp enable
//   write_en      out  1          write-driver enable
//   write_data    out  WORD_SIZE  data to the write drivers
//   mux_data      in   WORD_SIZE  column_mux data_out
// BEHAVIOUR
//   - Every output except req_ready is registered. req_ready = (state==IDLE), decoded from the state register.
//   - Reset: state IDLE. precharge_en, sense_en, write_en, rsp_valid are 0; row_sel, col_select, write_data,
//     rsp_rdata are all 0.
//   - FSM states: IDLE, PRECH, ACT, SENSE, WRITE, DONE.
//   - IDLE: on accept, latch addr, we and wdata; go to PRECH. Otherwise stay and hold all strobes low.
//   - PRECH (1 cycle): precharge_en=1; row_sel and col_select are 0. Go to ACT.
//   - ACT (1 cycle): row_sel=onehot(addr[7:4]), col_select=onehot(addr[3:0]), precharge_en=0.
//     Go to SENSE if it is a read, or to WRITE if it is a write.
//   - SENSE (1 cycle): row_sel and col_select held, sense_en=1. At the end of the cycle, capture mux_data
//     into rsp_rdata. Go to DONE.
//   - WRITE (1 cycle): row_sel and col_select held, write_en=1, write_data=latched wdata. Go to DONE.
//   - DONE (1 cycle): row_sel, col_select, sense_en and write_en all 0. rsp_valid=1 for reads only. Go to IDLE.
//   - Latency: accept at cycle N; rsp_valid in cycle N+4. The next accept is at N+5 at the earliest,
//     which gives a 5-cycle initiation interval.
//   - Strobe exclusivity: at most one of precharge_en, sense_en, write_en is high in any cycle.
//     row_sel and col_select are never high during precharge.
//   - req_valid while busy is ignored; no queueing. The requester holds it until req_ready.
//   - rsp has no backpressure; the consumer must sample the one-cycle pulse.
//   - Reset mid-operation: the next cycle is IDLE with all outputs at their reset values. The in-flight
//     access produces no rsp_valid. A partially driven write is undefined in the array.
//   - Addresses 0x00..0xFF are all legal; there is no wrap or range check.
// STRUCTURE
//   - Package sram_pkg: WORD_SIZE/NUM_WORDS/NUM_ROWS/ADDR_W constants, the FSM state encoding, and the
//     row/word field positions of the address.
//   - Sub-module onehot_decoder #(IN_W=4): binary to one-hot, with an enable input.
//     Instantiated twice, for row_sel and col_select.
// TESTING
//   - Reset: assert rst for 2 cycles -> req_ready=1; all strobes, row_sel, col_select, rsp_* are 0.
//   - Write addr 0x3A, data 0x5 -> PRECH, ACT, WRITE (write_en=1, row_sel=0x0008, col_select=0x0400,
//     write_data=0x5) -> req_ready again at N+5.
//   - Read addr 0x3A with mux_data=0x5 driven during SENSE -> rsp_valid at N+4 with rsp_rdata=0x5;
//     sense_en high exactly 1 cycle.
//   - Boundary addresses 0x00 and 0xFF -> row_sel/col_select = 0x0001/0x0001 and 0x8000/0x8000.
//   - req_valid held high through a read -> second request accepted exactly at N+5; no accept while busy.
//   - rst asserted in SENSE -> IDLE next cycle, no rsp_valid, rsp_rdata=0.
//   - Assertions every cycle: strobes are mutually exclusive, and row_sel and col_select are each one-hot or zero.

Source files
------------

// File: rtl/sram_access_ctrl_pkg.sv
// Package sram_pkg: shared constants for the SRAM access controller.
//   - Array geometry: WORD_SIZE, NUM_WORDS, NUM_ROWS, NUM_COLS, ADDR_W
//   - Address field positions: row in the upper nibble, word in the lower nibble
//   - FSM state encoding used by the controller
package sram_pkg;

  localparam int WORD_SIZE = 4;
  localparam int NUM_WORDS = 16;
  localparam int NUM_ROWS  = 16;
  localparam int NUM_COLS  = WORD_SIZE * NUM_WORDS;
  localparam int ADDR_W    = 8;

  localparam int ROW_LSB  = 4;
  localparam int ROW_W    = 4;
  localparam int WORD_LSB = 0;
  localparam int WORD_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRECH = 3'd1,
    ST_ACT   = 3'd2,
    ST_SENSE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/sram_access_ctrl_if.sv
// Interface sram_access_ctrl_if: request/response handshake between the
// Tiny Tapeout front end (master) and the SRAM access controller (slave).
//   req_valid/req_ready  request handshake, accepted when both are high
//   req_we/addr/wdata    request payload
//   rsp_valid/rsp_rdata  one-cycle read response pulse and read data
interface sram_access_ctrl_if;
  import sram_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_W-1:0]    req_addr;
  logic [WORD_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [WORD_SIZE-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/sram_access_ctrl_onehot_decoder.sv
// Module onehot_decoder: combinational binary to one-hot decoder.
//   en   in   1          when low the output is all zeros
//   bin  in   IN_W       binary index
//   dout out  2**IN_W    one-hot of bin, or zero when disabled
module onehot_decoder #(
  parameter int IN_W = 4
) (
  input  logic              en,
  input  logic [IN_W-1:0]   bin,
  output logic [2**IN_W-1:0] dout
);

  always_comb begin
    dout = '0;
    for (int i = 0; i < 2**IN_W; i++) begin
      dout[i] = en && (bin == i[IN_W-1:0]);
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Module sram_access_ctrl: sequences one SRAM access per accepted request
// (precharge, wordline/column select, then sense or write, then done).
//   clk, rst       clock and synchronous active-high reset
//   bus            request/response handshake (slave modport)
//   precharge_en   bitline precharge strobe
//   row_sel        one-hot wordline enable
//   col_select     one-hot column_mux select
//   sense_en       sense-amp enable
//   write_en       write-driver enable
//   write_data     data to the write drivers
//   mux_data       column_mux data_out, captured at the end of SENSE
module sram_access_ctrl
  import sram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sram_access_ctrl_if.slave    bus,
  output logic                 precharge_en,
  output logic [NUM_ROWS-1:0]  row_sel,
  output logic [NUM_WORDS-1:0] col_select,
  output logic                 sense_en,
  output logic                 write_en,
  output logic [WORD_SIZE-1:0] write_data,
  input  logic [WORD_SIZE-1:0] mux_data
);

  state_t               state;
  state_t               next_state;
  logic                 accept;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 sel_en;
  logic [NUM_ROWS-1:0]  row_dec;
  logic [NUM_WORDS-1:0] col_dec;

  assign bus.req_ready = (state == ST_IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_PRECH;
      ST_PRECH: next_state = ST_ACT;
      ST_ACT:   next_state = we_q ? ST_WRITE : ST_SENSE;
      ST_SENSE: next_state = ST_DONE;
      ST_WRITE: next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so each strobe is high exactly
  // in the cycle its state is current.
  assign sel_en = (next_state == ST_ACT) || (next_state == ST_SENSE) ||
                  (next_state == ST_WRITE);

  onehot_decoder #(.IN_W(ROW_W)) u_row_dec (
    .en   (sel_en),
    .bin  (addr_q[ROW_LSB +: ROW_W]),
    .dout (row_dec)
  );

  onehot_decoder #(.IN_W(WORD_W)) u_col_dec (
    .en   (sel_en),
    .bin  (addr_q[WORD_LSB +: WORD_W]),
    .dout (col_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // rsp_valid marks DONE of a read; DONE only follows SENSE on reads, so
  // registering "state is SENSE" gives the pulse without a separate flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      precharge_en  <= 1'b0;
      row_sel       <= '0;
      col_select    <= '0;
      sense_en      <= 1'b0;
      write_en      <= 1'b0;
      write_data    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      precharge_en  <= (next_state == ST_PRECH);
      row_sel       <= row_dec;
      col_select    <= col_dec;
      sense_en      <= (next_state == ST_SENSE);
      write_en      <= (next_state == ST_WRITE);
      write_data    <= (next_state == ST_WRITE) ? wdata_q : '0;
      bus.rsp_valid <= (state == ST_SENSE);
      if (state == ST_SENSE) bus.rsp_rdata <= mux_data;
    end
  end

endmodule
